feature_mem_rmw: RTL and testbench
==================================

# feature_mem_rmw

Read-modify-write controller that drives both ports of the dual-port feature memory, with 1-cycle read latency and 1-cycle write latency. It accepts update requests on a valid/ready interface, reads the old word on port A, and combines it lane-wise with the request data. It writes the result back on port B and reports old and new words. It sits between the event/graph front end and the feature memory, and provides per-node max-pooling and accumulation plus a full-memory clear.

## Interface
Parameters:
- AWIDTH, 16, memory address width.
- DWIDTH, 72, memory word width.
- LWIDTH, 8, lane width; DWIDTH must be a multiple of LWIDTH; LANES = DWIDTH/LWIDTH.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  pulse; starts a full-memory zero sweep.
- clr_done  out  1  one-cycle pulse when the sweep ends.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_op  in  2  operation code (see Operation).
- req_addr  in  AWIDTH  target address.
- req_data  in  DWIDTH  operand word.
- rsp_valid  out  1  response valid; no backpressure.
- rsp_addr  out  AWIDTH  response address.
- rsp_old  out  DWIDTH  word before the update.
- rsp_new  out  DWIDTH  word after the update.
- mem_ena, wea  out  1  port A enable and write; wea is tied to 0.
- addra  out  AWIDTH  port A read address.
- dina  out  DWIDTH  tied to 0.
- douta  in  DWIDTH  port A read data, valid 1 cycle after the read.
- mem_enb, web  out  1  port B enable and write.
- addrb  out  AWIDTH  port B address.
- dinb  out  DWIDTH  port B write data.
- doutb  in  DWIDTH  unused.

## Operation
- Operation codes:
  - OP_WRITE=0: new = req_data.
  - OP_MAX=1: new = lane-wise signed max(old, req_data).
  - OP_ADD=2: new = lane-wise signed saturating add; saturates at +2^(LWIDTH-1)-1 and -2^(LWIDTH-1); no carry between lanes.
  - OP_READ=3: new = old; no port B write.
- States: RUN, CLEAR. Reset enters RUN.
- Pipeline stage S0, accept cycle t: mem_ena=1 and addra=req_addr are driven combinationally from the handshake.
- Pipeline stage S1, cycle t+1:
  - old = douta, or the forwarded word on a hazard.
  - new is computed combinationally.
  - mem_enb=web=1 with addrb/dinb driven, except for OP_READ.
  - rsp_* are registered and valid at t+2.
- Readiness: req_ready = (state==RUN) && !clr && !stall.
- Hazard: an S0 read of the address that S1 writes in the same cycle returns stale data. This is handled per Configuration.
- clr handling in RUN:
  - clr takes priority over req_valid in the same cycle.
  - Any S1 operation in flight finishes its write first.
  - CLEAR starts the next cycle.
- CLEAR state:
  - Port B writes zero at addrb = 0 .. 2^AWIDTH-1, one address per cycle.
  - req_ready=0 and port A is idle.
  - After the last address, clr_done pulses for 1 cycle and the state returns to RUN.
  - clr asserted during CLEAR is ignored.
  - The address counter wraps to 0 exactly once, at the end of the sweep.
- Reset during any state: the pipeline is flushed (S1 valid cleared, no write issued the next cycle), the clear counter goes to 0, and the state goes to RUN.

## Timing
- Reset values: all outputs 0, including req_ready, mem_ena, mem_enb, web, rsp_valid and clr_done. req_ready goes to 1 in the first cycle after rst deasserts.
- Throughput: one request per cycle with no hazard.
- Latency: request accepted at t, memory written at the t+1 edge, response valid in cycle t+2.
- Back-to-back requests to the same address with forwarding: the second request sees the first request's new word as old.
- rsp_valid is high for exactly 1 cycle per accepted request, including OP_READ.

## Configuration
- RMW_FWD_EN defined:
  - If the S1-valid write address equals the address accepted in S0, the S1 new word is registered and used as old in the next cycle instead of douta.
  - No stall is inserted.
- RMW_FWD_EN undefined:
  - stall=1 when req_valid and req_addr equals the address of the valid S1 write.
  - This inserts one bubble; the request is accepted the next cycle and reads the committed data.
  - OP_READ in S1 never causes a stall.

## Structure
- Package rmw_pkg:
  - op_t enum (OP_WRITE, OP_MAX, OP_ADD, OP_READ).
  - state_t enum (RUN, CLEAR).
  - Lane saturation helper functions.
- Sub-module rmw_lane_alu: combinational; takes op, old and operand for one lane and outputs the new lane. Instantiated LANES times in a generate loop.
- Top level contains the FSM, the clear counter, the S1 pipeline register and the forwarding/stall logic.

## Test plan
Bench settings: AWIDTH=4, DWIDTH=32, LWIDTH=8, with the memory model attached.
- OP_WRITE 0x7F01FF80 to addr 3, then OP_READ addr 3: second rsp_old=0x7F01FF80, rsp_new equal to it, and no port B write for the read.
- OP_MAX with 0x05FA0010 on a word holding 0x03FB0020: rsp_new=0x05FB0020.
- OP_ADD with 0x01010180 on a word holding 0x7F7F0080: rsp_new=0x7F7F0180; lanes 0x7F+0x01 saturate to 0x7F, lane 0x00+0x01=0x01, and lane 0x80+0x80 saturates to 0x80.
- Consecutive OP_ADD 0x01010101 to addr 5 on a zero word: with RMW_FWD_EN, no stall and final value 0x03030303; without it, req_ready drops for exactly 1 cycle per hazard and the final value is the same.
- clr asserted together with req_valid after writes to addr 0 and 15:
  - The request is not accepted.
  - Exactly 16 port B zero writes occur, addresses 0..15.
  - clr_done pulses once, then RUN resumes.
  - Reads of addr 0 and 15 return 0.
- rst asserted mid-CLEAR at address 7 and then released: state is RUN, req_ready=1, no further clear writes, and all outputs were 0 during reset.

Source files
------------

// File: rtl/feature_mem_rmw_pkg.sv
// Shared types and lane helpers for the feature memory read-modify-write controller.
// Optional feature: RMW_FWD_EN (define to forward S1 results instead of stalling).
package rmw_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_MAX   = 2'd1,
        OP_ADD   = 2'd2,
        OP_READ  = 2'd3
    } op_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Signed-add overflow detect from the sign bits: {positive overflow, negative overflow}.
    function automatic logic [1:0] add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return {~a_msb & ~b_msb & s_msb, a_msb & b_msb & ~s_msb};
    endfunction

    // True when operand b is strictly greater than a, both read as signed lanes.
    function automatic logic signed_gt(input logic a_msb, input logic b_msb, input logic b_minus_a_neg,
                                       input logic equal);
        if (a_msb != b_msb) begin
            return a_msb;
        end
        return !b_minus_a_neg && !equal;
    endfunction

endpackage

// File: rtl/feature_mem_rmw_if.sv
// Request/response and dual-port memory bundle of the feature memory RMW controller.
// The controller uses the slave view; the front end plus memory use the master view.
interface feature_mem_rmw_if
    import rmw_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 72
);
    logic              req_valid;
    logic              req_ready;
    op_t               req_op;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_data;

    logic              rsp_valid;
    logic [AWIDTH-1:0] rsp_addr;
    logic [DWIDTH-1:0] rsp_old;
    logic [DWIDTH-1:0] rsp_new;

    logic              mem_ena;
    logic              wea;
    logic [AWIDTH-1:0] addra;
    logic [DWIDTH-1:0] dina;
    logic [DWIDTH-1:0] douta;

    logic              mem_enb;
    logic              web;
    logic [AWIDTH-1:0] addrb;
    logic [DWIDTH-1:0] dinb;
    logic [DWIDTH-1:0] doutb;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, douta, doutb,
        output req_ready, rsp_valid, rsp_addr, rsp_old, rsp_new,
        output mem_ena, wea, addra, dina, mem_enb, web, addrb, dinb
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, douta, doutb,
        input  req_ready, rsp_valid, rsp_addr, rsp_old, rsp_new,
        input  mem_ena, wea, addra, dina, mem_enb, web, addrb, dinb
    );

endinterface

// File: rtl/feature_mem_rmw_lane_alu.sv
// One lane of the RMW datapath: overwrite, signed max, signed saturating add, or pass-through.
module rmw_lane_alu
    import rmw_pkg::*;
#(
    parameter int LWIDTH = 8
) (
    input  op_t               op,
    input  logic [LWIDTH-1:0] old_lane,
    input  logic [LWIDTH-1:0] opd_lane,
    output logic [LWIDTH-1:0] new_lane
);

    logic [LWIDTH-1:0] sum;
    logic [LWIDTH-1:0] diff;
    logic [1:0]        ovf;
    logic              opd_bigger;

    assign sum        = old_lane + opd_lane;
    assign diff       = opd_lane - old_lane;
    assign ovf        = add_overflow(old_lane[LWIDTH-1], opd_lane[LWIDTH-1], sum[LWIDTH-1]);
    assign opd_bigger = signed_gt(old_lane[LWIDTH-1], opd_lane[LWIDTH-1], diff[LWIDTH-1],
                                  opd_lane == old_lane);

    // Select the lane result; add clamps to the signed extremes instead of wrapping.
    always_comb begin
        new_lane = old_lane;
        case (op)
            OP_WRITE: new_lane = opd_lane;
            OP_MAX:   new_lane = opd_bigger ? opd_lane : old_lane;
            OP_ADD: begin
                if (ovf[1]) begin
                    new_lane = {1'b0, {(LWIDTH-1){1'b1}}};
                end else if (ovf[0]) begin
                    new_lane = {1'b1, {(LWIDTH-1){1'b0}}};
                end else begin
                    new_lane = sum;
                end
            end
            default:  new_lane = old_lane;
        endcase
    end

endmodule

// File: rtl/feature_mem_rmw.sv
// Read-modify-write controller for the dual-port feature memory, with full-memory clear.
// Optional feature: RMW_FWD_EN forwards the S1 result on a same-address hazard;
// without it the hazarding request is stalled for one cycle.
module feature_mem_rmw
    import rmw_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 72,
    parameter int LWIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic            clr_done,
    feature_mem_rmw_if.slave bus
);

    localparam int LANES = DWIDTH / LWIDTH;

    state_t            state;
    logic [AWIDTH-1:0] clr_cnt;
    logic              clr_done_q;

    logic              s1_valid;
    op_t               s1_op;
    logic [AWIDTH-1:0] s1_addr;
    logic [DWIDTH-1:0] s1_opd;

    logic              rsp_valid_q;
    logic [AWIDTH-1:0] rsp_addr_q;
    logic [DWIDTH-1:0] rsp_old_q;
    logic [DWIDTH-1:0] rsp_new_q;

    logic [DWIDTH-1:0] old_word;
    logic [DWIDTH-1:0] new_word;
    logic              s1_write;
    logic              hazard;
    logic              stall;
    logic              ready;
    logic              accept;
    logic              unused_doutb;

    assign s1_write = s1_valid && (s1_op != OP_READ);
    assign hazard   = bus.req_valid && s1_write && (bus.req_addr == s1_addr);
    assign ready    = !rst && (state == RUN) && !clr && !stall;
    assign accept   = bus.req_valid && ready;

`ifdef RMW_FWD_EN
    logic              s1_fwd;
    logic [DWIDTH-1:0] fwd_word;

    // Keep S1's result when the request entering S1 reads the word S1 is writing right now.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_fwd   <= 1'b0;
            fwd_word <= '0;
        end else begin
            s1_fwd   <= accept && hazard;
            fwd_word <= new_word;
        end
    end

    assign old_word = s1_fwd ? fwd_word : bus.douta;
    assign stall    = 1'b0;
`else
    assign old_word = bus.douta;
    assign stall    = hazard;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        rmw_lane_alu #(
            .LWIDTH (LWIDTH)
        ) u_alu (
            .op       (s1_op),
            .old_lane (old_word[g*LWIDTH +: LWIDTH]),
            .opd_lane (s1_opd[g*LWIDTH +: LWIDTH]),
            .new_lane (new_word[g*LWIDTH +: LWIDTH])
        );
    end

    assign bus.req_ready = ready;
    assign bus.mem_ena   = accept;
    assign bus.addra     = accept ? bus.req_addr : '0;
    assign bus.wea       = 1'b0;
    assign bus.dina      = '0;
    assign unused_doutb  = ^bus.doutb;

    // Port B carries the clear sweep in CLEAR and the S1 write-back in RUN; silent during reset.
    always_comb begin
        bus.mem_enb = 1'b0;
        bus.web     = 1'b0;
        bus.addrb   = '0;
        bus.dinb    = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                bus.mem_enb = 1'b1;
                bus.web     = 1'b1;
                bus.addrb   = clr_cnt;
            end else if (s1_write) begin
                bus.mem_enb = 1'b1;
                bus.web     = 1'b1;
                bus.addrb   = s1_addr;
                bus.dinb    = new_word;
            end
        end
    end

    // Run/clear FSM, S1 pipeline register and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            clr_cnt     <= '0;
            clr_done_q  <= 1'b0;
            s1_valid    <= 1'b0;
            s1_op       <= OP_WRITE;
            s1_addr     <= '0;
            s1_opd      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_old_q   <= '0;
            rsp_new_q   <= '0;
        end else begin
            clr_done_q  <= 1'b0;
            rsp_valid_q <= s1_valid;
            rsp_addr_q  <= s1_addr;
            rsp_old_q   <= old_word;
            rsp_new_q   <= new_word;
            s1_valid    <= accept;
            if (accept) begin
                s1_op   <= bus.req_op;
                s1_addr <= bus.req_addr;
                s1_opd  <= bus.req_data;
            end
            case (state)
                RUN: begin
                    if (clr) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state      <= RUN;
                        clr_done_q <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign clr_done      = clr_done_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_old   = rsp_old_q;
    assign bus.rsp_new   = rsp_new_q;

endmodule

// File: tb/tb_feature_mem_rmw.sv
// Directed bench for feature_mem_rmw with a read-first dual-port memory model.
// Expectations follow RMW_FWD_EN when it is defined for the build.
module tb_feature_mem_rmw;
    import rmw_pkg::*;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] old_w;
        logic [31:0] new_w;
    } rsp_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        we;
    } wr_t;

    logic clk;
    logic rst;
    logic clr;
    logic clr_done;

    logic [31:0] mem [16];
    rsp_t        rsp_q [$];
    wr_t         wr_q [$];
    int          done_cnt;
    int          compared;
    int          mismatched;

    feature_mem_rmw_if #(.AWIDTH(4), .DWIDTH(32)) bus ();

    feature_mem_rmw #(
        .AWIDTH (4),
        .DWIDTH (32),
        .LWIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .clr_done (clr_done),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: port A read-first with one-cycle latency, port B write.
    always @(posedge clk) begin
        if (bus.mem_ena) bus.douta <= mem[bus.addra];
        if (bus.mem_enb && bus.web) mem[bus.addrb] <= bus.dinb;
    end

    // Monitor samples mid low phase, well away from the rising edge.
    always begin
        @(negedge clk);
        #3;
        if (bus.rsp_valid) rsp_q.push_back('{bus.rsp_addr, bus.rsp_old, bus.rsp_new});
        if (bus.mem_enb || bus.web) wr_q.push_back('{bus.addrb, bus.dinb, bus.web});
        if (clr_done) done_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one request from a negedge; returns at the negedge after it is accepted.
    task automatic applyStimulus(input op_t op, input logic [3:0] addr, input logic [31:0] data,
                                 output int stalls);
        logic acc;
        acc    = 1'b0;
        stalls = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        for (int i = 0; i < 20 && !acc; i++) begin
            #2;
            if (bus.req_ready) acc = 1'b1;
            else stalls++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        checkOutput($sformatf("accept addr%0d", addr), {63'd0, acc}, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkRsp(input string tag, input logic [3:0] addr, input logic [31:0] exp_old,
                            input logic [31:0] exp_new);
        rsp_t r;
        checkOutput({tag, " present"}, {63'd0, rsp_q.size() != 0}, 64'd1);
        if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            checkOutput({tag, " addr"}, {60'd0, r.addr}, {60'd0, addr});
            checkOutput({tag, " old"}, {32'd0, r.old_w}, {32'd0, exp_old});
            checkOutput({tag, " new"}, {32'd0, r.new_w}, {32'd0, exp_new});
        end
    endtask

    initial begin
        int s0, s1, s2, exp_stall, bad, done_start;
        compared   = 0;
        mismatched = 0;
        done_cnt   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        rst = 1'b1;
        clr = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_WRITE;
        bus.req_addr  = 4'd0;
        bus.req_data  = 32'd0;
        bus.doutb     = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        checkOutput("reset ctrl", {58'd0, bus.req_ready, bus.mem_ena, bus.mem_enb, bus.web,
                    bus.rsp_valid, clr_done}, 64'd0);
        checkOutput("reset rsp_new", {32'd0, bus.rsp_new}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("ready after reset", {63'd0, bus.req_ready}, 64'd1);
        @(negedge clk);

        // Write then read back; the read issues no port B write
        applyStimulus(OP_WRITE, 4'd3, 32'h7F01FF80, s0);
        idle(2);
        checkRsp("write3", 4'd3, 32'h0, 32'h7F01FF80);
        checkOutput("write3 portB count", wr_q.size(), 64'd1);
        if (wr_q.size() != 0) checkOutput("write3 portB", {27'd0, wr_q[0].we, wr_q[0].addr, wr_q[0].data},
                                          {27'd1, 4'd3, 32'h7F01FF80});
        wr_q.delete();
        applyStimulus(OP_READ, 4'd3, 32'hDEADBEEF, s0);
        idle(2);
        checkRsp("read3", 4'd3, 32'h7F01FF80, 32'h7F01FF80);
        checkOutput("read3 no portB", wr_q.size(), 64'd0);

        // Lane-wise signed max
        applyStimulus(OP_WRITE, 4'd6, 32'h03FB0020, s0);
        idle(2);
        checkRsp("preload6", 4'd6, 32'h0, 32'h03FB0020);
        applyStimulus(OP_MAX, 4'd6, 32'h05FA0010, s0);
        idle(2);
        checkRsp("max6", 4'd6, 32'h03FB0020, 32'h05FB0020);

        // Lane-wise saturating add, both saturation directions
        applyStimulus(OP_WRITE, 4'd7, 32'h7F7F0080, s0);
        idle(2);
        checkRsp("preload7", 4'd7, 32'h0, 32'h7F7F0080);
        applyStimulus(OP_ADD, 4'd7, 32'h01010180, s0);
        idle(2);
        checkRsp("add7", 4'd7, 32'h7F7F0080, 32'h7F7F0180);

        // Back-to-back adds to one address
`ifdef RMW_FWD_EN
        exp_stall = 0;
`else
        exp_stall = 1;
`endif
        applyStimulus(OP_ADD, 4'd5, 32'h01010101, s0);
        applyStimulus(OP_ADD, 4'd5, 32'h01010101, s1);
        applyStimulus(OP_ADD, 4'd5, 32'h01010101, s2);
        idle(3);
        checkOutput("hazard stall first", s0, 64'd0);
        checkOutput("hazard stall second", s1, exp_stall);
        checkOutput("hazard stall third", s2, exp_stall);
        checkRsp("add5 a", 4'd5, 32'h0, 32'h01010101);
        checkRsp("add5 b", 4'd5, 32'h01010101, 32'h02020202);
        checkRsp("add5 c", 4'd5, 32'h02020202, 32'h03030303);
        checkOutput("add5 mem", {32'd0, mem[5]}, {32'd0, 32'h03030303});

        // Clear sweep, clr wins over a same-cycle request
        applyStimulus(OP_WRITE, 4'd0, 32'h11223344, s0);
        applyStimulus(OP_WRITE, 4'd15, 32'hAABBCCDD, s0);
        idle(2);
        checkRsp("write0", 4'd0, 32'h0, 32'h11223344);
        checkRsp("write15", 4'd15, 32'h0, 32'hAABBCCDD);
        wr_q.delete();
        done_start = done_cnt;
        clr = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_WRITE;
        bus.req_addr  = 4'd9;
        bus.req_data  = 32'h12345678;
        #2;
        checkOutput("clr blocks request", {62'd0, bus.req_ready, bus.mem_ena}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        bus.req_valid = 1'b0;
        idle(3);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 40 && done_cnt == done_start; i++) @(negedge clk);
        idle(3);
        checkOutput("clr_done pulses", done_cnt - done_start, 64'd1);
        checkOutput("clear write count", wr_q.size(), 64'd16);
        bad = 0;
        for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
            if (wr_q[i].addr != 4'(i) || wr_q[i].data != 32'd0 || !wr_q[i].we) bad++;
        end
        checkOutput("clear write sequence", bad, 64'd0);
        checkOutput("clr request dropped", rsp_q.size(), 64'd0);
        applyStimulus(OP_READ, 4'd0, 32'd0, s0);
        applyStimulus(OP_READ, 4'd15, 32'd0, s0);
        idle(2);
        checkRsp("read0 cleared", 4'd0, 32'h0, 32'h0);
        checkRsp("read15 cleared", 4'd15, 32'h0, 32'h0);

        // Reset in the middle of a sweep
        done_start = done_cnt;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        idle(7);
        #2;
        checkOutput("sweep at addr7", {59'd0, bus.mem_enb, bus.addrb}, {59'd1, 4'd7});
        rst = 1'b1;
        wr_q.delete();
        @(negedge clk);
        #2;
        checkOutput("mid reset ctrl", {58'd0, bus.req_ready, bus.mem_ena, bus.mem_enb, bus.web,
                    bus.rsp_valid, clr_done}, 64'd0);
        checkOutput("mid reset portB", {28'd0, bus.addrb, bus.dinb}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("ready after mid reset", {63'd0, bus.req_ready}, 64'd1);
        @(negedge clk);
        idle(20);
        checkOutput("no writes after reset", wr_q.size(), 64'd0);
        checkOutput("no clr_done after reset", done_cnt - done_start, 64'd0);
        applyStimulus(OP_WRITE, 4'd9, 32'hCAFE0001, s0);
        idle(2);
        checkRsp("write9 after reset", 4'd9, 32'h0, 32'hCAFE0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
